// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the architectural HI/LO registers.
// Multiplies and divides compute their result on the accepting edge, park it in a
// pending register, and commit it to HI/LO after a fixed busy latency. mthi/mtlo
// write straight through without ever going busy.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxLat = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic              pend_ok_q, pend_ok_d;

    logic              accept, lat_op, last_cycle;
    logic [63:0]       a_sx, b_sx, mul_s, mul_u;
    logic              a_neg, b_neg;
    logic [31:0]       a_mag, b_mag, b_mag_nz, mag_q, mag_r, quo_s, rem_s;
    logic [31:0]       b_u_nz, quo_u, rem_u;

    assign accept     = start && (state_q == StIdle) && (md_op >= OpMult) && (md_op <= OpMtlo);
    assign lat_op     = (md_op >= OpMult) && (md_op <= OpDivu);
    assign last_cycle = (cnt_q == CntW'(1));

    // Full 64-bit products; sign/zero extension then keep the low 64 bits.
    always_comb begin
        a_sx  = {{32{src_a[31]}}, src_a};
        b_sx  = {{32{src_b[31]}}, src_b};
        mul_s = a_sx * b_sx;
        mul_u = {32'd0, src_a} * {32'd0, src_b};
    end

    // Signed divide via magnitudes: truncates toward zero, remainder takes the
    // dividend's sign, and 0x80000000 / -1 wraps to 0x80000000 without special-casing.
    // Zero divisors are replaced by 1 only to keep the divider defined; result is dropped.
    always_comb begin
        a_neg    = src_a[31];
        b_neg    = src_b[31];
        a_mag    = a_neg ? (32'd0 - src_a) : src_a;
        b_mag    = b_neg ? (32'd0 - src_b) : src_b;
        b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
        mag_q    = a_mag / b_mag_nz;
        mag_r    = a_mag % b_mag_nz;
        quo_s    = (a_neg ^ b_neg) ? (32'd0 - mag_q) : mag_q;
        rem_s    = a_neg ? (32'd0 - mag_r) : mag_r;
        b_u_nz   = (src_b == 32'd0) ? 32'd1 : src_b;
        quo_u    = src_a / b_u_nz;
        rem_u    = src_a % b_u_nz;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only latency ops leave idle; commit edge returns to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && lat_op) state_d = StRun;
            StRun:  if (last_cycle)       state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == StRun);
    end

    // Datapath next state: capture on accept, count down, commit on the final busy cycle.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        if (accept) begin
            case (md_op)
                OpMult: begin
                    {pend_hi_d, pend_lo_d} = mul_s;
                    pend_ok_d              = 1'b1;
                    cnt_d                  = CntW'(MULT_CYCLES);
                end
                OpMultu: begin
                    {pend_hi_d, pend_lo_d} = mul_u;
                    pend_ok_d              = 1'b1;
                    cnt_d                  = CntW'(MULT_CYCLES);
                end
                OpDiv: begin
                    pend_hi_d = rem_s;
                    pend_lo_d = quo_s;
                    pend_ok_d = (src_b != 32'd0);
                    cnt_d     = CntW'(DIV_CYCLES);
                end
                OpDivu: begin
                    pend_hi_d = rem_u;
                    pend_lo_d = quo_u;
                    pend_ok_d = (src_b != 32'd0);
                    cnt_d     = CntW'(DIV_CYCLES);
                end
                OpMthi:  hi_d = src_a;
                OpMtlo:  lo_d = src_a;
                default: ;
            endcase
        end else if (state_q == StRun) begin
            if (last_cycle) begin
                cnt_d = '0;
                if (pend_ok_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // Datapath registers; reset also discards any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic model.
module tb_md_unit;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .src_a(src_a),
        .src_b(src_b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {hi,lo} after the op commits, from plain integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
        int                ia, ib;
        longint            la, lb, q, r;
        longint unsigned   ua, ub;
        ia = a;
        ib = b;
        la = ia;
        lb = ib;
        ua = a;
        ub = b;
        case (op)
            3'd1: return la * lb;
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 32'd0) return {h, l};
                q = la / lb;
                r = la % lb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {h, l};
                return {a % b, a / b};
            end
            3'd5: return {a, l};
            3'd6: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    function automatic int unsigned ref_lat(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MULT_CYCLES;
        if (op == 3'd3 || op == 3'd4) return DIV_CYCLES;
        return 0;
    endfunction

    // Issue one op from idle, check busy window and HI/LO hold, then commit values.
    // With inject set, a stray start is raised on one busy cycle (possibly the commit cycle).
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
        logic [63:0] exp;
        int unsigned lat;
        int unsigned inj_k;
        exp   = ref_md(op, a, b, m_hi, m_lo);
        lat   = ref_lat(op);
        inj_k = (lat > 0) ? $urandom_range(lat - 1, 0) : 0;
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        md_op = 3'd0;
        src_a = $urandom;
        src_b = $urandom;
        for (int k = 0; k < int'(lat); k++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hold_hi"}, hi, m_hi);
            chk({tag, "_hold_lo"}, lo, m_lo);
            if (inject && k == int'(inj_k)) begin
                start = 1'b1;
                md_op = 3'($urandom_range(6, 1));
                src_a = $urandom;
                src_b = $urandom;
            end
            step();
            start = 1'b0;
            md_op = 3'd0;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp[63:32]);
        chk({tag, "_lo"}, lo, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Directed cases with hand-computed results.
        do_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_k_hi", hi, 32'hFFFF_FFFF);
        chk("mult_k_lo", lo, 32'hFFFF_FFFA);
        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_k_hi", hi, 32'hFFFF_FFFE);
        chk("multu_k_lo", lo, 32'h0000_0001);
        do_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_k_hi", hi, 32'hFFFF_FFFF);
        chk("div_k_lo", lo, 32'hFFFF_FFFD);
        do_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("divu_k_hi", hi, 32'h0000_0001);
        chk("divu_k_lo", lo, 32'h7FFF_FFFC);
        do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_k_hi", hi, 32'h0000_0000);
        chk("div_ovf_k_lo", lo, 32'h8000_0000);

        // Back-to-back mthi/mtlo.
        do_op("mthi", 3'd5, 32'h1234_5678, 32'd0, 1'b0);
        do_op("mtlo", 3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0);
        chk("mtx_k_hi", hi, 32'h1234_5678);
        chk("mtx_k_lo", lo, 32'h9ABC_DEF0);

        // Divide by zero keeps HI/LO; a mult started while busy is dropped.
        do_op("set_hi", 3'd5, 32'd1, 32'd0, 1'b0);
        do_op("set_lo", 3'd6, 32'd2, 32'd0, 1'b0);
        do_op("div0", 3'd3, 32'd77, 32'd0, 1'b1);
        chk("div0_k_hi", hi, 32'd1);
        chk("div0_k_lo", lo, 32'd2);
        do_op("divu0", 3'd4, 32'd77, 32'd0, 1'b1);
        chk("divu0_k_hi", hi, 32'd1);
        chk("divu0_k_lo", lo, 32'd2);

        // Ignored opcodes 0 and 7.
        do_op("nop0", 3'd0, 32'hDEAD_BEEF, 32'd5, 1'b0);
        do_op("nop7", 3'd7, 32'hDEAD_BEEF, 32'd5, 1'b0);

        // Asynchronous reset in the third busy cycle of a divide.
        start = 1'b1;
        md_op = 3'd3;
        src_a = 32'd100;
        src_b = 32'd7;
        step();
        start = 1'b0;
        md_op = 3'd0;
        step();
        step();
        chk("arst_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        step();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int k = 0; k < int'(DIV_CYCLES) + 2; k++) begin
            step();
            chk("arst_no_commit_busy", {31'd0, busy}, 32'd0);
            chk("arst_no_commit_hi", hi, 32'd0);
            chk("arst_no_commit_lo", lo, 32'd0);
        end

        // Randomized ops against the model, with occasional starts while busy.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(7, 0) == 0) a = 32'h8000_0000;
            case ($urandom_range(7, 0))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(9, 1));
                default: ;
            endcase
            do_op("rand", op, a, b, $urandom_range(2, 0) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
